i2s_transmitter: RTL and testbench
==================================

# i2s_transmitter

Serialises 16-bit stereo audio samples from the tone/noise datapath (post amplitude scaling and mixing) into a standard Philips I2S stream for the external audio DAC/codec. It generates BCLK and LRCLK from the 50 MHz system clock, buffers one stereo frame ahead of the one being shifted out, and applies backpressure through a valid/ready handshake. It sits at the output end of the sample pipeline, directly driving board pins.

## Interface
- CLK_DIV, 8: clk cycles per BCLK half-period (≥2). The default gives BCLK = 3.125 MHz and fs = 97.656 kHz.
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- enable  in  1  transmitter run; low = idle
- sample_l  in  16  left sample, two's complement
- sample_r  in  16  right sample, two's complement
- sample_valid  in  1  sample pair offered
- sample_ready  out  1  holding register empty; a transfer occurs when valid&&ready on a clk edge
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select: 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first
- frame_start  out  1  one-clk pulse when a new frame is loaded into the shifter
- underrun  out  1  one-clk pulse when a frame load finds the holding register empty

## Operation
- Frame: 32 BCLK periods; slots 0–15 carry left bits 15..0, and slots 16–31 carry right bits 15..0.
- Registers:
  - div_cnt counts 0..CLK_DIV-1.
  - bclk toggles when div_cnt hits terminal count.
  - bit_cnt is 5 bits and wraps 31→0.
  - shift_reg is 32 bits.
  - hold_reg is 32 bits, with hold_full.
- Rising BCLK toggle: no datapath action. DAC samples sdata here.
- Falling BCLK toggle:
  - bit_cnt increments (mod 32).
  - If the new bit_cnt==0, load shift_reg from hold_reg (frame = {L,R}), clear hold_full, and pulse frame_start. If hold_full was 0, load 32'h0 instead, and pulse both frame_start and underrun.
  - Otherwise shift_reg shifts left by 1.
  - sdata = shift_reg[31] after the update.
  - lrclk = bit ((bit_cnt+1) mod 32)[4], so LRCLK changes one BCLK before the MSB of each word (I2S 1-bit delay).
- Handshake:
  - sample_ready = !hold_full.
  - Acceptance sets hold_full and captures {sample_l, sample_r}.
- Simultaneous events:
  - Acceptance in the same clk as a load that sees hold_full=0: underrun is taken and zeros are sent. The accepted pair stays held for the next frame.
  - Acceptance while hold_full=1 is impossible (ready low).
- enable low: div_cnt=0, bclk=0, bit_cnt=31, shift_reg=0, sdata=0, lrclk=0. hold_reg/hold_full are retained, and the handshake still operates. Deassertion mid-frame abandons that frame immediately. On re-enable, output restarts exactly as after reset.

## Timing
- Reset values:
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0
  - frame_start=0, underrun=0
  - sample_ready=1
  - bit_cnt=31, div_cnt=0, hold_full=0
- BCLK period = 2·CLK_DIV clk. Frame = 64·CLK_DIV clk.
- With enable high from cycle 0:
  - The first rising BCLK is visible at cycle CLK_DIV.
  - The first falling BCLK and first load are visible at cycle 2·CLK_DIV.
  - The left MSB appears on sdata in that same cycle.
- All outputs are registered. sdata and lrclk change only coincident with falling BCLK, which gives ≥ CLK_DIV clk setup/hold around rising BCLK.
- sample_ready returns high the cycle after each load. One sample pair may be accepted per frame. A source must deliver within 64·CLK_DIV clk of ready rising to avoid underrun.
- Asynchronous reset mid-frame: all state returns to reset values immediately, and the held sample is discarded.

## Structure
- Shared package audio_pkg holds I2S_SLOT_BITS=16, I2S_FRAME_BITS=32, SYS_CLK_HZ=50_000_000, and typedef logic signed [15:0] sample_t (shared with the mixer/amplitude path).
- One sub-module: i2s_clk_gen (div_cnt, bclk, bit_cnt, fall_tick/enable handling). The top level holds hold_reg, shift_reg, the handshake and the pulses.

## Test plan
- Reset/idle: hold reset, then release with enable=0 for 200 clk -> bclk=lrclk=sdata=0, sample_ready=1, no pulses.
- Single frame, CLK_DIV=2: accept L=16'hA5F0, R=16'h0F0F at cycle 0, enable=1 -> first falling BCLK at cycle 4 with frame_start. Sampling sdata at 32 rising BCLKs yields 32'hA5F00F0F. LRCLK rises at the falling edge where bit_cnt becomes 15.
- Underrun: no second pair supplied -> at the next bit_cnt wrap (cycle 4+128), underrun and frame_start pulse together, and 32 zero bits are sent.
- Backpressure: hold valid high with incrementing pairs -> sample_ready is low except for one acceptance per frame. Every frame carries consecutive pairs with none lost or duplicated, and underrun never fires.
- Simultaneous: offer the first pair exactly in the clk of a load with hold_full=0 -> underrun for that frame, and the pair appears in the following frame.
- Enable drop mid-frame at bit_cnt=10, re-enable 50 clk later with a held pair -> outputs idle immediately. The restarted frame begins 2·CLK_DIV clk after re-enable and carries the held pair.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the sample pipeline and the I2S output stage.
package audio_pkg;

  localparam int I2S_SLOT_BITS  = 16;
  localparam int I2S_FRAME_BITS = 32;
  localparam int I2S_CNT_BITS   = $clog2(I2S_FRAME_BITS);
  localparam int SYS_CLK_HZ     = 50_000_000;

  typedef logic signed [I2S_SLOT_BITS-1:0] sample_t;
  typedef logic [I2S_FRAME_BITS-1:0]       frame_t;

  // Left word goes out first, so it occupies the upper half of the frame.
  function automatic frame_t pack_frame(input sample_t left, input sample_t right);
    return {left, right};
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK/LRCLK generator: divides clk into BCLK and tracks the bit slot within the frame.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    fall_tick,
  output logic [I2S_CNT_BITS-1:0] bit_next
);

  localparam int                DIV_W  = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [I2S_CNT_BITS-1:0] bit_cnt;
  logic [I2S_CNT_BITS-1:0] lr_idx;
  logic                    div_tc;

  assign div_tc    = (div_cnt == DIV_TC);
  assign fall_tick = enable && div_tc && bclk;
  assign bit_next  = bit_cnt + 1'b1;
  // Word select leads the data by one slot (I2S one-bit delay).
  assign lr_idx    = bit_cnt + 2'd2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
      lrclk   <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
      lrclk   <= 1'b0;
    end else if (div_tc) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
      if (bclk) begin
        bit_cnt <= bit_next;
        lrclk   <= lr_idx[I2S_CNT_BITS-1];
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S transmitter: one-frame holding register with valid/ready intake, 32-bit shifter.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [I2S_SLOT_BITS-1:0] sample_l,
  input  logic [I2S_SLOT_BITS-1:0] sample_r,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  output logic                     i2s_bclk,
  output logic                     i2s_lrclk,
  output logic                     i2s_sdata,
  output logic                     frame_start,
  output logic                     underrun
);

  logic                    fall_tick;
  logic [I2S_CNT_BITS-1:0] bit_next;
  logic                    hold_full;
  frame_t                  hold_reg;
  frame_t                  shift_reg;
  logic                    accept;
  logic                    load;

  i2s_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bclk      (i2s_bclk),
    .lrclk     (i2s_lrclk),
    .fall_tick (fall_tick),
    .bit_next  (bit_next)
  );

  assign sample_ready = !hold_full;
  assign accept       = sample_valid && !hold_full;
  assign load         = fall_tick && (bit_next == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full   <= 1'b0;
      hold_reg    <= '0;
      shift_reg   <= '0;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (accept) begin
        hold_reg  <= pack_frame(sample_t'(sample_l), sample_t'(sample_r));
        hold_full <= 1'b1;
      end
      if (!enable) begin
        shift_reg <= '0;
        i2s_sdata <= 1'b0;
      end else if (load) begin
        frame_start <= 1'b1;
        // A pair accepted in this same cycle stays held for the following frame.
        hold_full   <= accept;
        if (hold_full) begin
          shift_reg <= hold_reg;
          i2s_sdata <= hold_reg[I2S_FRAME_BITS-1];
        end else begin
          shift_reg <= '0;
          i2s_sdata <= 1'b0;
          underrun  <= 1'b1;
        end
      end else if (fall_tick) begin
        shift_reg <= {shift_reg[I2S_FRAME_BITS-2:0], 1'b0};
        i2s_sdata <= shift_reg[I2S_FRAME_BITS-2];
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: cycle-time reference model plus a deserializer on the I2S pins.
module tb_i2s_transmitter;

  localparam int CD = 2;
  localparam int FR = 64 * CD;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_start;
  logic        underrun;

  always #5 clk = ~clk;

  i2s_transmitter #(.CLK_DIV(CD)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: n = clk edges since enable was seen high; everything follows from n.
  int          n;
  logic        m_full, m_ld, m_acc, e_fs, e_ur;
  logic [31:0] m_hold, cur_word;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; m_full = 0; m_hold = 0; cur_word = 0; e_fs = 0; e_ur = 0;
    end else begin
      m_acc = sample_valid && !m_full;
      n     = enable ? n + 1 : 0;
      m_ld  = enable && (n >= 2*CD) && ((n - 2*CD) % FR == 0);
      e_fs  = m_ld;
      e_ur  = m_ld && !m_full;
      if (!enable) cur_word = 0;
      if (m_ld) cur_word = m_full ? m_hold : 32'h0;
      if (m_ld) m_full = m_acc;
      else if (m_acc) m_full = 1'b1;
      if (m_acc) m_hold = {sample_l, sample_r};
    end
  end

  function automatic int slot_of(input int nn);
    return (nn / (2*CD) - 1) % 32;
  endfunction

  // Per-cycle comparison against the model, plus pulse counters and pin deserializer.
  int          ur_cnt = 0, fs_cnt = 0, rx_cnt = -1;
  logic        prev_bclk = 0;
  logic [31:0] rx_sh;
  logic [31:0] rx_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      int  s;
      logic e_lr, e_sd;
      s    = slot_of(n);
      e_lr = (n >= 2*CD) ? (((s + 1) % 32) >= 16) : 1'b0;
      e_sd = (n >= 2*CD) ? cur_word[31 - s] : 1'b0;
      check("bclk",  i2s_bclk,     ((n / CD) % 2) == 1);
      check("lrclk", i2s_lrclk,    e_lr);
      check("sdata", i2s_sdata,    e_sd);
      check("fs",    frame_start,  e_fs);
      check("ur",    underrun,     e_ur);
      check("ready", sample_ready, !m_full);
    end
    if (underrun) ur_cnt++;
    if (frame_start) fs_cnt++;
    if (reset || !enable) rx_cnt = -1;
    else if (frame_start) begin
      rx_cnt = 0; rx_sh = 0;
    end else if (i2s_bclk && !prev_bclk && rx_cnt >= 0) begin
      rx_sh = {rx_sh[30:0], i2s_sdata};
      rx_cnt++;
      if (rx_cnt == 32) begin
        rx_q.push_back(rx_sh);
        rx_cnt = -1;
      end
    end
    prev_bclk = i2s_bclk;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rx(input int cnt, input int budget);
    int i = 0;
    while (rx_q.size() < cnt && i < budget) begin tick(); i++; end
    check("rx_timeout", rx_q.size() >= cnt, 1'b1);
  endtask

  task automatic wait_until_slot(input int s, input int budget);
    int i = 0;
    while (!(n >= 2*CD && slot_of(n) == s) && i < budget) begin tick(); i++; end
    check("slot_timeout", i < budget, 1'b1);
  endtask

  initial begin
    logic [31:0] p, q, pair;
    logic [31:0] acc_q[$];
    int k, k2, ur0, i;
    logic tx;

    reset = 1; enable = 0; sample_valid = 0; sample_l = 0; sample_r = 0;
    repeat (3) tick();
    check("rst_bclk",  i2s_bclk, 0);
    check("rst_lrclk", i2s_lrclk, 0);
    check("rst_sdata", i2s_sdata, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_fs",    frame_start, 0);
    check("rst_ur",    underrun, 0);
    reset = 0;
    repeat (200) tick();
    check("idle_fs_cnt", fs_cnt, 0);
    check("idle_ur_cnt", ur_cnt, 0);

    // Single frame: pair offered together with enable.
    sample_l = 16'hA5F0; sample_r = 16'h0F0F; sample_valid = 1; enable = 1;
    tick(); sample_valid = 0;
    tick();
    check("first_rise", i2s_bclk, 1);
    tick(); tick();
    check("first_fall_bclk", i2s_bclk, 0);
    check("first_fall_fs",   frame_start, 1);
    check("first_msb",       i2s_sdata, 1);
    wait_rx(1, FR + 20);
    check("frame0", rx_q[0], 32'hA5F00F0F);

    // Underrun: nothing offered for the second frame.
    wait_rx(2, FR + 20);
    check("underrun_zero", rx_q[1], 32'h0);
    check("underrun_cnt",  ur_cnt, 1);

    // Offer a pair exactly on the clk of a load with the holding register empty.
    i = 0;
    while (!((n + 1 - 2*CD) % FR == 0) && i < 2*FR) begin tick(); i++; end
    p = $urandom;
    sample_l = p[31:16]; sample_r = p[15:0]; sample_valid = 1;
    k = rx_q.size();
    tick(); sample_valid = 0;
    check("sim_ur", underrun, 1);
    check("sim_fs", frame_start, 1);

    // Backpressure: valid held high with incrementing pairs.
    ur0 = ur_cnt;
    pair = $urandom;
    sample_l = pair[31:16]; sample_r = pair[15:0]; sample_valid = 1;
    tx = 0;
    repeat (6 * FR) begin
      if (tx) begin
        acc_q.push_back(pair);
        pair = pair + 32'h0001_0001;
        sample_l = pair[31:16]; sample_r = pair[15:0];
      end
      tx = sample_ready;
      tick();
    end
    sample_valid = 0;
    if (tx) acc_q.push_back(pair);
    check("bp_accept_count", acc_q.size() >= 5, 1'b1);
    wait_rx(k + 2 + acc_q.size(), (acc_q.size() + 3) * FR);
    check("sim_frame_zero", rx_q[k], 32'h0);
    check("sim_frame_pair", rx_q[k + 1], p);
    for (int j = 0; j < acc_q.size(); j++)
      check("bp_frame", rx_q[k + 2 + j], acc_q[j]);
    check("bp_no_underrun", ur_cnt, ur0);

    // Enable drop at bit_cnt=10 with a pair held, then restart.
    i = 0;
    while (!frame_start && i < 2*FR) begin tick(); i++; end
    q = $urandom;
    sample_l = q[31:16]; sample_r = q[15:0]; sample_valid = 1;
    tick(); sample_valid = 0;
    wait_until_slot(10, FR);
    enable = 0;
    tick();
    check("drop_bclk",  i2s_bclk, 0);
    check("drop_lrclk", i2s_lrclk, 0);
    check("drop_sdata", i2s_sdata, 0);
    check("drop_ready", sample_ready, 0);
    repeat (49) tick();
    k2 = rx_q.size();
    enable = 1;
    repeat (2*CD) tick();
    check("restart_fs", frame_start, 1);
    check("restart_ur", underrun, 0);
    wait_rx(k2 + 1, FR + 20);
    check("restart_frame", rx_q[k2], q);

    // Asynchronous reset mid-frame discards the held pair.
    q = $urandom;
    sample_l = q[31:16]; sample_r = q[15:0]; sample_valid = 1;
    tick(); sample_valid = 0;
    wait_until_slot(7, FR);
    #2 reset = 1;
    #1;
    check("arst_bclk",  i2s_bclk, 0);
    check("arst_lrclk", i2s_lrclk, 0);
    check("arst_sdata", i2s_sdata, 0);
    check("arst_ready", sample_ready, 1);
    tick();
    reset = 0;
    repeat (2*CD) tick();
    check("arst_restart_fs", frame_start, 1);
    check("arst_restart_ur", underrun, 1);
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
